// File: rtl/debug_regs_pkg.sv
// Shared constants for the Wishbone debug register bank: register map layout,
// CTRL/STATUS bit positions and a byte-lane merge helper.
package debug_regs_pkg;

  localparam int          NUM_REGS_DEFAULT  = 4;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h30FF_FFF0;

  // CTRL and CYCLE_CNT always occupy the top two slots, whatever NUM_REGS is.
  localparam int CTRL_OFFSET_FROM_TOP = 2;
  localparam int CNT_OFFSET_FROM_TOP  = 1;

  localparam int CTRL_CNT_EN_BIT  = 0;
  localparam int CTRL_CNT_CLR_BIT = 1;
  localparam int CTRL_OVF_BIT     = 8;

  typedef enum logic [1:0] {
    REG_SCRATCH,
    REG_CTRL,
    REG_CNT
  } reg_kind_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) merged[8*b +: 8] = new_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_debug_regbank_if.sv
// Wishbone classic slave bus bundle for the debug register bank.
interface wb_debug_regbank_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/dbg_cycle_counter.sv
// Free-running 32-bit cycle counter with enable, synchronous clear and a
// sticky overflow flag that is cleared by a write-1 pulse.
module dbg_cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        ovf_clr,
  output logic [31:0] count,
  output logic        ovf
);

  logic [31:0] count_q;
  logic        ovf_q;
  logic        wrap;

  assign wrap = en & ~clr & (count_q == 32'hFFFF_FFFF);

  // Clear beats increment; a wrap in the same cycle as a W1C keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (clr) begin
        count_q <= '0;
      end else if (en) begin
        count_q <= count_q + 32'd1;
      end
      if (wrap) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/wb_debug_regbank.sv
// Wishbone slave exposing scratch registers, a CTRL/STATUS register and a
// read-only cycle counter, with single-cycle registered acknowledge.
module wb_debug_regbank
  import debug_regs_pkg::*;
#(
  parameter int          NUM_REGS  = NUM_REGS_DEFAULT,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  wb_debug_regbank_if.slave        wbs,
  output logic [31:0]              dbg_scratch0_o,
  output logic                     cnt_ovf_o
);

  localparam int             AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0]  CTRL_IDX = AW'(NUM_REGS - CTRL_OFFSET_FROM_TOP);
  localparam logic [AW-1:0]  CNT_IDX  = AW'(NUM_REGS - CNT_OFFSET_FROM_TOP);

  logic          hit;
  logic          req;
  logic          wr;
  logic [AW-1:0] idx;
  reg_kind_e     kind;
  logic          ctrl_wr;
  logic          ovf_clr;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic [31:0]   rd_data;
  logic [31:0]   scratch_q [NUM_REGS];
  logic          cnt_en_q;
  logic          cnt_clr_q;
  logic [31:0]   count;
  logic          ovf;
  logic          unused_adr_bits;

  assign hit = wbs.wbs_cyc_i & wbs.wbs_stb_i &
               (wbs.wbs_adr_i[31:2+AW] == BASE_ADDR[31:2+AW]);
  assign idx = wbs.wbs_adr_i[2+AW-1:2];
  assign unused_adr_bits = ^wbs.wbs_adr_i[1:0];

  // A request is the first cycle of a hit; the held-strobe cycle after an ack
  // is ignored so a stalled master sees one ack per access.
  assign req = hit & ~ack_q;
  assign wr  = req & wbs.wbs_we_i;

  always_comb begin
    kind = REG_SCRATCH;
    if (idx == CTRL_IDX) begin
      kind = REG_CTRL;
    end else if (idx == CNT_IDX) begin
      kind = REG_CNT;
    end
  end

  assign ctrl_wr = wr & (kind == REG_CTRL);
  assign ovf_clr = ctrl_wr & wbs.wbs_sel_i[1] & wbs.wbs_dat_i[CTRL_OVF_BIT];

  always_comb begin
    rd_data = '0;
    case (kind)
      REG_SCRATCH: rd_data = scratch_q[idx];
      REG_CTRL: begin
        rd_data[CTRL_CNT_EN_BIT] = cnt_en_q;
        rd_data[CTRL_OVF_BIT]    = ovf;
      end
      REG_CNT:     rd_data = count;
      default:     rd_data = '0;
    endcase
  end

  // Read data is only loaded on a read request so the bus data is zero
  // in every cycle that does not carry an ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      ack_q     <= req;
      dat_q     <= (req && !wbs.wbs_we_i) ? rd_data : '0;
      cnt_clr_q <= ctrl_wr & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[CTRL_CNT_CLR_BIT];
      if (ctrl_wr && wbs.wbs_sel_i[0]) begin
        cnt_en_q <= wbs.wbs_dat_i[CTRL_CNT_EN_BIT];
      end
    end
  end

  // Slots holding CTRL and CYCLE_CNT are never written and stay at zero.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr && (kind == REG_SCRATCH) && (idx == AW'(i))) begin
          scratch_q[i] <= byte_merge(scratch_q[i], wbs.wbs_dat_i, wbs.wbs_sel_i);
        end
      end
    end
  end

  dbg_cycle_counter u_counter (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .en      (cnt_en_q),
    .clr     (cnt_clr_q),
    .ovf_clr (ovf_clr),
    .count   (count),
    .ovf     (ovf)
  );

  assign wbs.wbs_ack_o  = ack_q;
  assign wbs.wbs_dat_o  = dat_q;
  assign dbg_scratch0_o = scratch_q[0];
  assign cnt_ovf_o      = ovf;

endmodule

// File: tb/tb_wb_debug_regbank.sv
// Directed scoreboard bench for wb_debug_regbank (NUM_REGS=4, base 0x30FF_FFF0);
// a negedge monitor pops expected read data on every ack.
module tb_wb_debug_regbank;

  localparam logic [31:0] BASE   = 32'h30FF_FFF0;
  localparam logic [31:0] A_S0   = 32'h30FF_FFF0;
  localparam logic [31:0] A_S1   = 32'h30FF_FFF4;
  localparam logic [31:0] A_CTRL = 32'h30FF_FFF8;
  localparam logic [31:0] A_CNT  = 32'h30FF_FFFC;
  localparam logic [31:0] A_MISS = 32'h30FF_FFE0;
  localparam logic [31:0] A_FAR  = 32'h20FF_FFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dbg_scratch0;
  logic        cnt_ovf;

  wb_debug_regbank_if bus();

  wb_debug_regbank #(
    .NUM_REGS  (4),
    .BASE_ADDR (BASE)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .wbs            (bus),
    .dbg_scratch0_o (dbg_scratch0),
    .cnt_ovf_o      (cnt_ovf)
  );

  always #5 clk = ~clk;

  string       name_q [$];
  bit          read_q [$];
  logic [31:0] lo_q   [$];
  logic [31:0] hi_q   [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        prev_ack = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] lo, input logic [31:0] hi);
    vectors++;
    if ($isunknown(actual) || actual < lo || actual > hi) begin
      miscompares++;
      if (lo == hi)
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, lo);
      else
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h..0x%08h", name, actual, lo, hi);
    end
  endtask

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
  endtask

  task automatic bus_drive(input bit we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
  endtask

  task automatic push_expect(input string name, input bit is_read,
                             input logic [31:0] lo, input logic [31:0] hi);
    name_q.push_back(name);
    read_q.push_back(is_read);
    lo_q.push_back(lo);
    hi_q.push_back(hi);
  endtask

  // One access: ack must appear exactly one cycle after the request edge and
  // drop again in the following cycle.
  task automatic apply_stimulus(input string name, input bit we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel,
                                input bit expect_hit, input logic [31:0] lo,
                                input logic [31:0] hi);
    @(negedge clk);
    bus_drive(we, adr, dat, sel);
    if (expect_hit) push_expect(name, !we, lo, hi);
    @(posedge clk);
    #1;
    check_output({name, "_ack"}, {31'b0, bus.wbs_ack_o}, {31'b0, expect_hit}, {31'b0, expect_hit});
    @(negedge clk);
    bus_idle();
    @(posedge clk);
    #1;
    check_output({name, "_ack_width"}, {31'b0, bus.wbs_ack_o}, 32'd0, 32'd0);
  endtask

  task automatic hold_read4(input logic [31:0] adr, input logic [31:0] expected);
    @(negedge clk);
    bus_drive(1'b0, adr, 32'h0, 4'hF);
    push_expect("held_read_a", 1'b1, expected, expected);
    push_expect("held_read_b", 1'b1, expected, expected);
    #1;
    check_output("held_c0", {31'b0, bus.wbs_ack_o}, 32'd0, 32'd0);
    @(posedge clk); #1;
    check_output("held_c1", {31'b0, bus.wbs_ack_o}, 32'd1, 32'd1);
    @(posedge clk); #1;
    check_output("held_c2", {31'b0, bus.wbs_ack_o}, 32'd0, 32'd0);
    @(posedge clk); #1;
    check_output("held_c3", {31'b0, bus.wbs_ack_o}, 32'd1, 32'd1);
    @(negedge clk);
    bus_idle();
    @(posedge clk); #1;
    check_output("held_after", {31'b0, bus.wbs_ack_o}, 32'd0, 32'd0);
  endtask

  initial begin : monitor
    string       n;
    bit          r;
    logic [31:0] lo;
    logic [31:0] hi;
    forever begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) begin
        check_output("ack_back_to_back", {31'b0, prev_ack}, 32'd0, 32'd0);
        check_output("ack_expected", 32'(name_q.size()), 32'd1, 32'hFFFF_FFFF);
        if (name_q.size() > 0) begin
          n  = name_q.pop_front();
          r  = read_q.pop_front();
          lo = lo_q.pop_front();
          hi = hi_q.pop_front();
          if (r) check_output(n, bus.wbs_dat_o, lo, hi);
        end
      end else begin
        check_output("dat_zero_without_ack", bus.wbs_dat_o, 32'd0, 32'd0);
      end
      prev_ack = (bus.wbs_ack_o === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    bus_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_ack", {31'b0, bus.wbs_ack_o}, 32'd0, 32'd0);
    check_output("reset_scratch0", dbg_scratch0, 32'd0, 32'd0);
    check_output("reset_ovf", {31'b0, cnt_ovf}, 32'd0, 32'd0);
    rst_n = 1'b1;

    apply_stimulus("wr_s0_full",  1'b1, A_S0, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 32'h0);
    apply_stimulus("wr_s0_byte0", 1'b1, A_S0, 32'h0000_00AA, 4'h1, 1'b1, 32'h0, 32'h0);
    apply_stimulus("rd_s0",       1'b0, A_S0, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEAA, 32'hDEAD_BEAA);
    check_output("dbg_scratch0", dbg_scratch0, 32'hDEAD_BEAA, 32'hDEAD_BEAA);
    apply_stimulus("wr_s1_lanes", 1'b1, A_S1, 32'h1234_5678, 4'b1010, 1'b1, 32'h0, 32'h0);
    apply_stimulus("rd_s1",       1'b0, A_S1, 32'h0, 4'hF, 1'b1, 32'h1200_5600, 32'h1200_5600);
    apply_stimulus("wr_s0_sel0",  1'b1, A_S0, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0, 32'h0);
    apply_stimulus("rd_s0_sel0",  1'b0, A_S0, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEAA, 32'hDEAD_BEAA);

    hold_read4(A_S0, 32'hDEAD_BEAA);
    apply_stimulus("wr_miss",     1'b1, A_MISS, 32'h5555_5555, 4'hF, 1'b0, 32'h0, 32'h0);
    apply_stimulus("rd_miss",     1'b0, A_MISS, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0);
    apply_stimulus("rd_far",      1'b0, A_FAR, 32'h0, 4'hF, 1'b0, 32'h0, 32'h0);
    apply_stimulus("rd_s0_nomod", 1'b0, A_S0, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEAA, 32'hDEAD_BEAA);

    apply_stimulus("rd_cnt_idle", 1'b0, A_CNT, 32'h0, 4'hF, 1'b1, 32'd0, 32'd0);
    apply_stimulus("wr_ctrl_en",  1'b1, A_CTRL, 32'h1, 4'hF, 1'b1, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    apply_stimulus("rd_cnt_run",  1'b0, A_CNT, 32'h0, 4'hF, 1'b1, 32'd10, 32'd12);
    apply_stimulus("wr_ctrl_clr", 1'b1, A_CTRL, 32'h3, 4'hF, 1'b1, 32'h0, 32'h0);
    apply_stimulus("rd_cnt_clr",  1'b0, A_CNT, 32'h0, 4'hF, 1'b1, 32'd0, 32'd3);
    apply_stimulus("rd_ctrl",     1'b0, A_CTRL, 32'h0, 4'hF, 1'b1, 32'h1, 32'h1);
    apply_stimulus("wr_cnt_ro",   1'b1, A_CNT, 32'h1234, 4'hF, 1'b1, 32'h0, 32'h0);
    apply_stimulus("rd_cnt_ro",   1'b0, A_CNT, 32'h0, 4'hF, 1'b1, 32'd0, 32'd10);

    check_output("ovf_before_wrap", {31'b0, cnt_ovf}, 32'd0, 32'd0);
    @(negedge clk);
    force dut.u_counter.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_counter.count_q;
    @(negedge clk);
    check_output("ovf_at_max", {31'b0, cnt_ovf}, 32'd0, 32'd0);
    @(negedge clk);
    check_output("ovf_after_wrap", {31'b0, cnt_ovf}, 32'd1, 32'd1);
    apply_stimulus("rd_cnt_wrap", 1'b0, A_CNT, 32'h0, 4'hF, 1'b1, 32'd1, 32'd1);
    apply_stimulus("rd_ctrl_ovf", 1'b0, A_CTRL, 32'h0, 4'hF, 1'b1, 32'h101, 32'h101);
    apply_stimulus("wr_ctrl_w1c", 1'b1, A_CTRL, 32'h100, 4'h2, 1'b1, 32'h0, 32'h0);
    check_output("ovf_w1c", {31'b0, cnt_ovf}, 32'd0, 32'd0);
    apply_stimulus("rd_ctrl_w1c", 1'b0, A_CTRL, 32'h0, 4'hF, 1'b1, 32'h1, 32'h1);

    @(negedge clk);
    force dut.u_counter.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_counter.count_q;
    apply_stimulus("wr_w1c_wrap", 1'b1, A_CTRL, 32'h100, 4'h2, 1'b1, 32'h0, 32'h0);
    check_output("ovf_set_wins", {31'b0, cnt_ovf}, 32'd1, 32'd1);
    apply_stimulus("rd_ctrl_set", 1'b0, A_CTRL, 32'h0, 4'hF, 1'b1, 32'h101, 32'h101);

    @(negedge clk);
    bus_drive(1'b1, A_S1, 32'hCAFE_F00D, 4'hF);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("rst_mid_ack", {31'b0, bus.wbs_ack_o}, 32'd0, 32'd0);
    check_output("rst_mid_dat", bus.wbs_dat_o, 32'd0, 32'd0);
    @(posedge clk); #1;
    check_output("rst_hold_ack", {31'b0, bus.wbs_ack_o}, 32'd0, 32'd0);
    @(negedge clk);
    bus_idle();
    check_output("rst_scratch0", dbg_scratch0, 32'd0, 32'd0);
    check_output("rst_ovf", {31'b0, cnt_ovf}, 32'd0, 32'd0);
    rst_n = 1'b1;
    apply_stimulus("post_rst_s0",   1'b0, A_S0, 32'h0, 4'hF, 1'b1, 32'h0, 32'h0);
    apply_stimulus("post_rst_s1",   1'b0, A_S1, 32'h0, 4'hF, 1'b1, 32'h0, 32'h0);
    apply_stimulus("post_rst_ctrl", 1'b0, A_CTRL, 32'h0, 4'hF, 1'b1, 32'h0, 32'h0);
    apply_stimulus("post_rst_cnt",  1'b0, A_CNT, 32'h0, 4'hF, 1'b1, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    check_output("scoreboard_drained", 32'(name_q.size()), 32'd0, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
